// File: rtl/pb_debouncer.sv
// ----------------------------------------------------------------------------
// pb_debouncer
//   Conditions a raw mechanical push-button for the one_pulser stage that
//   follows. The pad is synchronised with a two-flop chain and then qualified
//   by a four-state FSM: a new level is accepted only after STABLE_CYCLES+1
//   consecutive synchronised samples agree. The clean level on pbDB feeds
//   one_pulser's clkPB input, so each accepted edge yields exactly one SP.
//
//   Optional build macro:
//     PB_INVERT_EN - active-low board buttons. The pad is inverted before the
//                    synchroniser, so pbDB stays active-high (1 = pressed).
//
//   Reset is synchronous and active-low (rst == 0 at a rising edge).
// ----------------------------------------------------------------------------
module pb_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic pbRaw,
    output logic pbDB,
    output logic busy
);

    // Encoding is chosen so that bit 1 is the debounced level and bit 0 marks
    // a candidate change being qualified; both outputs are then plain flop
    // outputs with no decode logic behind them.
    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b10,
        ST_FALL = 2'b11
    } state_t;

    // Terminal count: the sample that arrives while the counter holds this
    // value is the (STABLE_CYCLES+1)-th consecutive one, so it commits.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_pb_in;
    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

`ifdef PB_INVERT_EN
    // Active-low button: pressed pulls the pad to 0.
    assign w_pb_in = ~pbRaw;
`else
    assign w_pb_in = pbRaw;
`endif

    // Two-flop synchroniser for the asynchronous pad; cleared by reset so a
    // released button never produces a spurious edge after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= w_pb_in;
            r_s2 <= r_s1;
        end
    end

    // State and stability counter registers; reset overrides any transition
    // and discards a partially qualified count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic. The counter only advances while a candidate level
    // keeps agreeing; every other path (entry, abort, commit, idle) clears it,
    // so it never exceeds LP_CNT_LAST and can never wrap.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            ST_LOW: begin
                if (r_s2) begin
                    w_state_next = ST_RISE;
                end
            end
            ST_RISE: begin
                if (!r_s2) begin
                    w_state_next = ST_LOW;           // bounce: give up
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_next = ST_HIGH;          // qualified press
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!r_s2) begin
                    w_state_next = ST_FALL;
                end
            end
            ST_FALL: begin
                if (r_s2) begin
                    w_state_next = ST_HIGH;          // bounce: give up
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_next = ST_LOW;           // qualified release
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_LOW;
            end
        endcase
    end

    assign pbDB = r_state[1];
    assign busy = r_state[0];

endmodule

// File: tb/tb_pb_debouncer.sv
// ----------------------------------------------------------------------------
// tb_pb_debouncer
//   Directed bench for pb_debouncer (STABLE_CYCLES = 16, 2 ns clock).
//   A run-length model of the debouncing rule is checked against pbDB/busy on
//   every falling edge; directed sequences add literal latency/level checks
//   and count one_pulser-style SP pulses on pbDB. Works for both polarity
//   builds (PB_INVERT_EN defined or not).
// ----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_pb_debouncer;

    localparam int STABLE = 16;
    localparam int LAT    = STABLE + 3;   // edges from new pad level to pbDB change
`ifdef PB_INVERT_EN
    localparam logic PRESS = 1'b0;
`else
    localparam logic PRESS = 1'b1;
`endif
    localparam logic RELEASE = ~PRESS;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic pbRaw = RELEASE;
    logic pbDB;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    pb_debouncer #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (20)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pbRaw(pbRaw),
        .pbDB (pbDB),
        .busy (busy)
    );

    always #1 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Level m_db changes once the synchronised input has disagreed with it on
    // STABLE+1 consecutive edges; m_run is the current disagreeing run length.
    logic m_d1    = 1'b0;
    logic m_d2    = 1'b0;
    logic m_db    = 1'b0;
    int   m_run   = 0;
    int   m_rises = 0;
    logic m_valid = 1'b0;

    initial begin : model
        logic s;
        logic pressed;
        forever begin
            @(posedge clk);
            pressed = (pbRaw == PRESS);
            if (!rst) begin
                m_d1  = 1'b0;
                m_d2  = 1'b0;
                m_db  = 1'b0;
                m_run = 0;
            end else begin
                s = m_d2;
                m_d2 = m_d1;
                m_d1 = pressed;
                if (s != m_db) begin
                    m_run = m_run + 1;
                    if (m_run == STABLE + 1) begin
                        m_db  = ~m_db;
                        m_run = 0;
                        if (m_db) m_rises = m_rises + 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_valid = 1'b1;
        end
    end

    // ---------------- per-cycle compare + one_pulser SP count ----------------
    int   sp_cnt  = 0;
    logic sp_prev = 1'b0;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_valid) begin
                n_tests++;
                if (pbDB !== m_db) begin
                    n_fail++;
                    $display("FAIL model_pbDB t=%0t got=%b exp=%b", $time, pbDB, m_db);
                end
                n_tests++;
                if (busy !== (m_run != 0)) begin
                    n_fail++;
                    $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, (m_run != 0));
                end
                if (pbDB === 1'b1 && sp_prev === 1'b0) sp_cnt++;
                sp_prev = pbDB;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #0.5;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Step until pbDB reaches lvl; edges = -1 if the bound expires.
    task automatic wait_db(input logic lvl, input int limit, output int edges);
        edges = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (pbDB === lvl) begin
                edges = k;
                break;
            end
        end
    endtask

    // From a settled opposite level, hold a new level for n edges and check
    // the exact edge-by-edge timeline of pbDB and busy.
    task automatic hold_check(input string name, input logic nl, input int n);
        pbRaw = nl ? PRESS : RELEASE;
        for (int k = 1; k <= n; k++) begin
            step();
            chk_bit({name, "_db"},   pbDB, (k >= LAT) ? nl : ~nl);
            chk_bit({name, "_busy"}, busy, (k >= 3 && k < LAT));
        end
        $display("[TB] %s: level %0b held %0d edges", name, nl, n);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int e;
        int sp0;

        // 1. Reset with button pressed, then release reset.
        rst   = 1'b0;
        pbRaw = PRESS;
        repeat (3) begin
            step();
            chk_bit("t1_rst_db",   pbDB, 1'b0);
            chk_bit("t1_rst_busy", busy, 1'b0);
        end
        rst = 1'b1;
        wait_db(1'b1, 40, e);
        chk_int("t1_rise_latency", e, LAT);
        $display("[TB] t1: rise %0d edges after reset release", e);

        // 2. Clean release / press / release.
        hold_check("t2_release", 1'b0, 40);
        hold_check("t2_press",   1'b1, 40);
        hold_check("t2_release2", 1'b0, 40);

        // 3. Bounce: 4 x (high 5, low 3), then held high.
        sp0 = sp_cnt;
        for (int r = 0; r < 4; r++) begin
            pbRaw = PRESS;
            repeat (5) begin step(); chk_bit("t3_bounce_db", pbDB, 1'b0); end
            pbRaw = RELEASE;
            repeat (3) begin step(); chk_bit("t3_bounce_db", pbDB, 1'b0); end
        end
        pbRaw = PRESS;
        wait_db(1'b1, 40, e);
        chk_int("t3_rise_latency", e, LAT);
        repeat (20) step();
        chk_int("t3_sp_once", sp_cnt - sp0, 1);
        $display("[TB] t3: bounce then rise after %0d edges", e);
        hold_check("t3_release", 1'b0, 40);

        // 4a. Glitch of 16 samples: rejected.
        pbRaw = PRESS;
        repeat (16) begin step(); chk_bit("t4_glitch16_db", pbDB, 1'b0); end
        pbRaw = RELEASE;
        repeat (20) begin step(); chk_bit("t4_glitch16_db", pbDB, 1'b0); end
        chk_bit("t4_glitch16_busy", busy, 1'b0);
        $display("[TB] t4: 16-sample glitch rejected");

        // 4b. 17 samples: accepted at the boundary.
        pbRaw = PRESS;
        e = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 17) pbRaw = RELEASE;
            if (pbDB === 1'b1 && e < 0) e = k;
        end
        chk_int("t4_pulse17_rise", e, LAT);
        repeat (20) step();
        chk_bit("t4_pulse17_settle_db", pbDB, 1'b0);
        $display("[TB] t4: 17-sample pulse rose at edge %0d", e);

        // 5a. Reset in RISE with count at 10.
        pbRaw = PRESS;
        repeat (13) step();
        chk_bit("t5_rise_busy", busy, 1'b1);
        chk_bit("t5_rise_db",   pbDB, 1'b0);
        rst = 1'b0;
        step();
        chk_bit("t5_rst_rise_db",   pbDB, 1'b0);
        chk_bit("t5_rst_rise_busy", busy, 1'b0);
        rst = 1'b1;
        wait_db(1'b1, 40, e);
        chk_int("t5_rerise_latency", e, LAT);
        $display("[TB] t5: reset in RISE, re-rise after %0d edges", e);

        // 5b. Reset in FALL.
        pbRaw = RELEASE;
        repeat (10) step();
        chk_bit("t5_fall_db",   pbDB, 1'b1);
        chk_bit("t5_fall_busy", busy, 1'b1);
        rst = 1'b0;
        step();
        chk_bit("t5_rst_fall_db",   pbDB, 1'b0);
        chk_bit("t5_rst_fall_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (25) begin step(); chk_bit("t5_after_rst_db", pbDB, 1'b0); end
        $display("[TB] t5: reset in FALL clears pbDB");

        // 6. One SP per accepted press over the whole run.
        step();
        chk_int("t6_sp_total",    sp_cnt, 5);
        chk_int("t6_sp_vs_model", sp_cnt, m_rises);
        $display("[TB] t6: %0d SP pulses counted", sp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
